// File: rtl/freq_period_ctrl.sv
// freq_period_ctrl
//   Chooses the frequency counter's update period. Two requesters share the
//   counter: a front-panel button that steps through four presets, and a host
//   link that writes an explicit period as a header byte (0xA, period[11:8])
//   followed by a low byte. Host writes take priority over button presses.
//   After reset the default period is always loaded once.
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   btn_next     in   raw asynchronous preset-advance button
//   host_data    in   host byte
//   host_valid   in   host byte valid
//   host_ready   out  controller can accept a host byte
//   period       out  period value to the counter, held between loads
//   period_load  out  one-cycle load strobe to the counter
//   preset_idx   out  currently selected preset
module freq_period_ctrl #(
    parameter int unsigned BITS       = 12,
    parameter int unsigned PRESET0    = 1200,
    parameter int unsigned PRESET1    = 2400,
    parameter int unsigned PRESET2    = 600,
    parameter int unsigned PRESET3    = 120,
    parameter int unsigned MIN_PERIOD = 16,
    parameter int unsigned DEBOUNCE   = 8,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            btn_next,
    input  logic [7:0]      host_data,
    input  logic            host_valid,
    output logic            host_ready,
    output logic [BITS-1:0] period,
    output logic            period_load,
    output logic [1:0]      preset_idx
);

    localparam int unsigned DBW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int unsigned TOW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StInit, StIdle, StWaitLo, StLoad} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [BITS-1:0] r_period;
    logic [BITS-1:0] w_period_nxt;
    logic [1:0]      r_preset_idx;
    logic [1:0]      w_preset_idx_nxt;
    logic [3:0]      r_hi;
    logic [3:0]      w_hi_nxt;
    logic [TOW-1:0]  r_to_cnt;
    logic [TOW-1:0]  w_to_cnt_nxt;
    logic            r_pending;
    logic            w_pend_clr;

    logic            r_btn_meta;
    logic            r_btn_sync;
    logic [DBW-1:0]  r_db_cnt;
    logic            r_db_fired;
    logic            w_press;

    logic            w_accept;
    logic [11:0]     w_host_raw;
    logic [BITS-1:0] w_host_period;

    function automatic logic [BITS-1:0] preset_val(input logic [1:0] idx);
        logic [BITS-1:0] v;
        case (idx)
            2'd0:    v = BITS'(PRESET0);
            2'd1:    v = BITS'(PRESET1);
            2'd2:    v = BITS'(PRESET2);
            default: v = BITS'(PRESET3);
        endcase
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Button: synchroniser, stability counter, sticky pending flag
    // ------------------------------------------------------------------
    // The counter stops once the event has fired; r_db_fired blocks a new
    // event until the synchronised level drops.
    assign w_press = r_btn_sync && !r_db_fired && (r_db_cnt == DBW'(DEBOUNCE - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_meta <= 1'b0;
            r_btn_sync <= 1'b0;
            r_db_cnt   <= '0;
            r_db_fired <= 1'b0;
            r_pending  <= 1'b0;
        end else begin
            r_btn_meta <= btn_next;
            r_btn_sync <= r_btn_meta;
            if (!r_btn_sync) begin
                r_db_cnt   <= '0;
                r_db_fired <= 1'b0;
            end else if (w_press) begin
                r_db_fired <= 1'b1;
            end else if (!r_db_fired) begin
                r_db_cnt <= r_db_cnt + DBW'(1);
            end
            // A fresh event in the servicing cycle survives the clear.
            r_pending <= w_press | (r_pending & ~w_pend_clr);
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    assign host_ready  = (r_state == StIdle) || (r_state == StWaitLo);
    assign w_accept    = host_valid && host_ready;
    assign period_load = (r_state == StLoad);
    assign period      = r_period;
    assign preset_idx  = r_preset_idx;

    assign w_host_raw    = {r_hi, host_data};
    assign w_host_period = (32'(w_host_raw) < MIN_PERIOD) ? BITS'(MIN_PERIOD)
                                                          : BITS'(w_host_raw);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StInit;
            r_period     <= BITS'(PRESET0);
            r_preset_idx <= 2'd0;
            r_hi         <= 4'd0;
            r_to_cnt     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_period     <= w_period_nxt;
            r_preset_idx <= w_preset_idx_nxt;
            r_hi         <= w_hi_nxt;
            r_to_cnt     <= w_to_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_period_nxt     = r_period;
        w_preset_idx_nxt = r_preset_idx;
        w_hi_nxt         = r_hi;
        w_to_cnt_nxt     = r_to_cnt;
        w_pend_clr       = 1'b0;
        case (r_state)
            StInit: begin
                // r_period already holds the default from reset.
                w_state_nxt = StLoad;
            end
            StIdle: begin
                if (w_accept && (host_data[7:4] == 4'hA)) begin
                    w_hi_nxt     = host_data[3:0];
                    w_to_cnt_nxt = '0;
                    w_state_nxt  = StWaitLo;
                end else if (r_pending) begin
                    // Any non-header byte accepted here is simply dropped.
                    w_preset_idx_nxt = r_preset_idx + 2'd1;
                    w_period_nxt     = preset_val(r_preset_idx + 2'd1);
                    w_pend_clr       = 1'b1;
                    w_state_nxt      = StLoad;
                end
            end
            StWaitLo: begin
                if (w_accept) begin
                    w_period_nxt = w_host_period;
                    w_state_nxt  = StLoad;
                end else if (r_to_cnt == TOW'(TIMEOUT)) begin
                    w_state_nxt = StIdle;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + TOW'(1);
                end
            end
            StLoad: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StInit;
            end
        endcase
    end

endmodule
